// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit: forwarding mux encodings,
// stall-timer FSM states and the timer counter sizing helper.
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      MEM_WAIT,
      MUL_BUSY
   } timer_state_t;

   // Width of a down-counter able to hold the larger of the two latencies.
   function automatic int cnt_width(input int load_lat, input int mul_lat);
      int m;
      m = (load_lat > mul_lat) ? load_lat : mul_lat;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/hazard_mc_stall_timer.sv
// Multi-cycle stall sequencer: tracks variable-latency memory accesses in M
// and multi-cycle multiplies in E, raising mem_stall / mul_stall for the
// cycles the pipeline must stay frozen. Memory waits win over multiplies;
// because E stays frozen during a memory wait, a pending multiply is picked
// up in the memory release cycle so the two stall windows run back-to-back.
module stall_timer
   import hazard_pkg::*;
#(
   parameter int LOAD_LAT = 1,
   parameter int MUL_LAT  = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic mem_req,
   input  logic mul_start,
   output logic mem_stall,
   output logic mul_stall
);

   localparam int CW = cnt_width(LOAD_LAT, MUL_LAT);
   localparam bit MEM_EN = (LOAD_LAT > 0);
   localparam bit MUL_EN = (MUL_LAT > 1);
   // The entry cycle is itself a stall cycle, so a memory wait reloads
   // LOAD_LAT-1 to give LOAD_LAT stalls in total, and a multiply reloads
   // MUL_LAT-2 to give MUL_LAT-1 stalls (the final E cycle overlaps release).
   localparam logic [CW-1:0] MEM_LOAD = MEM_EN ? CW'(LOAD_LAT - 1) : '0;
   localparam logic [CW-1:0] MUL_LOAD = MUL_EN ? CW'(MUL_LAT - 2) : '0;

   timer_state_t state, state_next;
   logic [CW-1:0] cnt, cnt_next;

   // State and counter registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state, counter reload/decrement and stall request decode.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      mem_stall  = 1'b0;
      mul_stall  = 1'b0;
      case (state)
         IDLE: begin
            if (MEM_EN && mem_req) begin
               mem_stall  = 1'b1;
               state_next = MEM_WAIT;
               cnt_next   = MEM_LOAD;
            end else if (MUL_EN && mul_start) begin
               mul_stall  = 1'b1;
               state_next = MUL_BUSY;
               cnt_next   = MUL_LOAD;
            end
         end
         MEM_WAIT: begin
            if (cnt != '0) begin
               mem_stall = 1'b1;
               cnt_next  = cnt - 1'b1;
            end else if (MUL_EN && mul_start) begin
               mul_stall  = 1'b1;
               state_next = MUL_BUSY;
               cnt_next   = MUL_LOAD;
            end else begin
               state_next = IDLE;
            end
         end
         MUL_BUSY: begin
            if (cnt != '0) begin
               mul_stall = 1'b1;
               cnt_next  = cnt - 1'b1;
            end else if (MEM_EN && mem_req) begin
               mem_stall  = 1'b1;
               state_next = MEM_WAIT;
               cnt_next   = MEM_LOAD;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_mc.sv
// Pipeline hazard unit: M/W operand forwarding (or interlocking when
// forwarding is disabled), load-use stalls, PC-write/branch flushes and
// multi-cycle memory/multiply freezes from the stall timer.
module hazard_mc
   import hazard_pkg::*;
#(
   parameter int ADDR_W   = 4,
   parameter bit FWD_EN   = 1'b1,
   parameter int LOAD_LAT = 1,
   parameter int MUL_LAT  = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] RA1D,
   input  logic [ADDR_W-1:0] RA2D,
   input  logic [ADDR_W-1:0] RA1E,
   input  logic [ADDR_W-1:0] RA2E,
   input  logic [ADDR_W-1:0] WA3E,
   input  logic [ADDR_W-1:0] WA3M,
   input  logic [ADDR_W-1:0] WA3W,
   input  logic              RegWriteE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              MemtoRegE,
   input  logic              MemReqM,
   input  logic              MulStartE,
   input  logic              PCSrcD,
   input  logic              PCSrcE,
   input  logic              PCSrcM,
   input  logic              PCSrcW,
   input  logic              BranchTakenE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic              FlushW
);

   logic mem_stall, mul_stall;
   logic [1:0] fwd_a, fwd_b;
   logic data_stall, pc_wr_pending;

   stall_timer #(
      .LOAD_LAT (LOAD_LAT),
      .MUL_LAT  (MUL_LAT)
   ) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .mem_req   (MemReqM),
      .mul_start (MulStartE),
      .mem_stall (mem_stall),
      .mul_stall (mul_stall)
   );

   // Operand forwarding select; the younger result in M beats W.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (FWD_EN) begin
         if (RegWriteM && (RA1E == WA3M))      fwd_a = FWD_M;
         else if (RegWriteW && (RA1E == WA3W)) fwd_a = FWD_W;
         if (RegWriteM && (RA2E == WA3M))      fwd_b = FWD_M;
         else if (RegWriteW && (RA2E == WA3W)) fwd_b = FWD_W;
      end
   end

   // Data hazard detection: load-use with forwarding, otherwise interlock on
   // any pending E/M write (W writes the register file in the first half).
   always_comb begin
      data_stall    = 1'b0;
      pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;
      if (FWD_EN) begin
         data_stall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
      end else begin
         data_stall = (RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E))) ||
                      (RegWriteM && ((RA1D == WA3M) || (RA2D == WA3M)));
      end
   end

   // Pipeline enable/flush drive; freezes override normal flushes, and all
   // outputs drop to zero while reset is held.
   always_comb begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      StallF    = data_stall | pc_wr_pending;
      StallD    = data_stall;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = pc_wr_pending | PCSrcW | BranchTakenE;
      FlushE    = data_stall | BranchTakenE;
      FlushM    = 1'b0;
      FlushW    = 1'b0;
      if (mem_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushD = 1'b0;
         FlushE = 1'b0;
         FlushM = 1'b0;
         FlushW = 1'b1;
      end else if (mul_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         FlushD = 1'b0;
         FlushE = 1'b0;
         FlushM = 1'b1;
      end
      if (!reset_n) begin
         ForwardAE = FWD_RF;
         ForwardBE = FWD_RF;
         StallF    = 1'b0;
         StallD    = 1'b0;
         StallE    = 1'b0;
         StallM    = 1'b0;
         FlushD    = 1'b0;
         FlushE    = 1'b0;
         FlushM    = 1'b0;
         FlushW    = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_mc.sv
// Directed bench for hazard_mc: a main instance (forwarding, LOAD_LAT=3,
// MUL_LAT=3), a no-forwarding instance and a single-cycle-memory instance,
// all driven from the same stimulus.
module tb_hazard_mc;

   logic clk = 1'b0;
   logic reset_n;
   logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
   logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemReqM, MulStartE;
   logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;

   logic [1:0] d_FwdA, d_FwdB, nf_FwdA, nf_FwdB, l0_FwdA, l0_FwdB;
   logic d_StallF, d_StallD, d_StallE, d_StallM, d_FlushD, d_FlushE, d_FlushM, d_FlushW;
   logic nf_StallF, nf_StallD, nf_StallE, nf_StallM, nf_FlushD, nf_FlushE, nf_FlushM, nf_FlushW;
   logic l0_StallF, l0_StallD, l0_StallE, l0_StallM, l0_FlushD, l0_FlushE, l0_FlushM, l0_FlushW;

   int checks = 0;
   int errors = 0;
   int stall_cycles;

   always #5 clk = ~clk;

   hazard_mc #(.ADDR_W(4), .FWD_EN(1'b1), .LOAD_LAT(3), .MUL_LAT(3)) d (
      .clk(clk), .reset_n(reset_n),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemReqM(MemReqM), .MulStartE(MulStartE),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE),
      .ForwardAE(d_FwdA), .ForwardBE(d_FwdB),
      .StallF(d_StallF), .StallD(d_StallD), .StallE(d_StallE), .StallM(d_StallM),
      .FlushD(d_FlushD), .FlushE(d_FlushE), .FlushM(d_FlushM), .FlushW(d_FlushW)
   );

   hazard_mc #(.ADDR_W(4), .FWD_EN(1'b0), .LOAD_LAT(3), .MUL_LAT(3)) nf (
      .clk(clk), .reset_n(reset_n),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemReqM(MemReqM), .MulStartE(MulStartE),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE),
      .ForwardAE(nf_FwdA), .ForwardBE(nf_FwdB),
      .StallF(nf_StallF), .StallD(nf_StallD), .StallE(nf_StallE), .StallM(nf_StallM),
      .FlushD(nf_FlushD), .FlushE(nf_FlushE), .FlushM(nf_FlushM), .FlushW(nf_FlushW)
   );

   hazard_mc #(.ADDR_W(4), .FWD_EN(1'b1), .LOAD_LAT(0), .MUL_LAT(3)) l0 (
      .clk(clk), .reset_n(reset_n),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemReqM(MemReqM), .MulStartE(MulStartE),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE),
      .ForwardAE(l0_FwdA), .ForwardBE(l0_FwdB),
      .StallF(l0_StallF), .StallD(l0_StallD), .StallE(l0_StallE), .StallM(l0_StallM),
      .FlushD(l0_FlushD), .FlushE(l0_FlushE), .FlushM(l0_FlushM), .FlushW(l0_FlushW)
   );

   // A write-back PC update can never coincide with a multiply freeze.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && d_StallE && d_FlushM && !d_StallM) begin
         assert (PCSrcW !== 1'b1) else begin
            errors++;
            $error("[TB] FAIL illegal_pcsrcw_in_mul observed=%0b required=0", PCSrcW);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
      end
   endtask

   task automatic clearInputs();
      RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
      WA3E = '0; WA3M = '0; WA3W = '0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemtoRegE = 1'b0; MemReqM = 1'b0; MulStartE = 1'b0;
      PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
      BranchTakenE = 1'b0;
   endtask

   // Advance one clock; inputs change 1ns after the rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset: outputs forced low even with hazard-provoking inputs.
      reset_n = 1'b0;
      clearInputs();
      PCSrcE = 1'b1; RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; MemReqM = 1'b1;
      #3;
      checkOutput("rst_fwdA", d_FwdA, 2'b00);
      checkOutput("rst_stallF", d_StallF, 1'b0);
      checkOutput("rst_flushD", d_FlushD, 1'b0);
      checkOutput("rst_stallM", d_StallM, 1'b0);
      clearInputs();
      applyStimulus();
      reset_n = 1'b1;
      applyStimulus();

      // Forwarding priority M over W, then W, then no match.
      RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1; RA2E = 4'd5;
      #1;
      checkOutput("fwdA_M", d_FwdA, 2'b10);
      checkOutput("fwdB_none", d_FwdB, 2'b00);
      checkOutput("nf_fwdA", nf_FwdA, 2'b00);
      RegWriteM = 1'b0;
      #1;
      checkOutput("fwdA_W", d_FwdA, 2'b01);
      RA2E = 4'd3;
      #1;
      checkOutput("fwdB_W", d_FwdB, 2'b01);
      clearInputs();
      applyStimulus();

      // Load-use stall for exactly one cycle.
      MemtoRegE = 1'b1; WA3E = 4'd2; RA2D = 4'd2;
      #1;
      checkOutput("ldr_stallF", d_StallF, 1'b1);
      checkOutput("ldr_stallD", d_StallD, 1'b1);
      checkOutput("ldr_flushE", d_FlushE, 1'b1);
      checkOutput("ldr_stallE", d_StallE, 1'b0);
      applyStimulus();
      MemtoRegE = 1'b0; WA3E = 4'd0;
      #1;
      checkOutput("ldr_after_stallD", d_StallD, 1'b0);
      checkOutput("ldr_after_flushE", d_FlushE, 1'b0);
      clearInputs();
      applyStimulus();

      // No-forwarding interlock on an M write; W alone does not interlock.
      RegWriteM = 1'b1; WA3M = 4'd4; RA1D = 4'd4; RA1E = 4'd4;
      #1;
      checkOutput("nf_stallF", nf_StallF, 1'b1);
      checkOutput("nf_stallD", nf_StallD, 1'b1);
      checkOutput("nf_flushE", nf_FlushE, 1'b1);
      checkOutput("nf_fwdA_M", nf_FwdA, 2'b00);
      checkOutput("fwd_no_stallD", d_StallD, 1'b0);
      checkOutput("fwd_fwdA_M", d_FwdA, 2'b10);
      RegWriteM = 1'b0; RegWriteW = 1'b1; WA3W = 4'd4;
      #1;
      checkOutput("nf_W_no_stall", nf_StallD, 1'b0);
      clearInputs();
      applyStimulus();

      // Memory wait: three frozen cycles, released on the fourth.
      MemReqM = 1'b1;
      #1;
      checkOutput("mem0_stallF", d_StallF, 1'b1);
      checkOutput("mem0_stallE", d_StallE, 1'b1);
      checkOutput("mem0_stallM", d_StallM, 1'b1);
      checkOutput("mem0_flushW", d_FlushW, 1'b1);
      checkOutput("mem0_flushM", d_FlushM, 1'b0);
      checkOutput("l0_no_stallM", l0_StallM, 1'b0);
      checkOutput("l0_no_stallF", l0_StallF, 1'b0);
      applyStimulus();
      checkOutput("mem1_stallM", d_StallM, 1'b1);
      applyStimulus();
      checkOutput("mem2_stallM", d_StallM, 1'b1);
      checkOutput("mem2_flushW", d_FlushW, 1'b1);
      applyStimulus();
      checkOutput("mem3_rel_stallM", d_StallM, 1'b0);
      checkOutput("mem3_rel_stallF", d_StallF, 1'b0);
      checkOutput("mem3_rel_flushW", d_FlushW, 1'b0);
      MemReqM = 1'b0;
      applyStimulus();
      checkOutput("mem_idle_stallM", d_StallM, 1'b0);
      applyStimulus();

      // Multiply held in E: two frozen cycles.
      MulStartE = 1'b1;
      #1;
      checkOutput("mul0_stallE", d_StallE, 1'b1);
      checkOutput("mul0_flushM", d_FlushM, 1'b1);
      checkOutput("mul0_stallM", d_StallM, 1'b0);
      checkOutput("mul0_flushE", d_FlushE, 1'b0);
      applyStimulus();
      checkOutput("mul1_stallE", d_StallE, 1'b1);
      checkOutput("mul1_flushM", d_FlushM, 1'b1);
      applyStimulus();
      checkOutput("mul2_rel_stallE", d_StallE, 1'b0);
      checkOutput("mul2_rel_flushM", d_FlushM, 1'b0);
      MulStartE = 1'b0;
      applyStimulus();

      // Memory and multiply together: 3 memory stalls, then 2 multiply stalls.
      MemReqM = 1'b1; MulStartE = 1'b1;
      #1;
      checkOutput("both0_stallM", d_StallM, 1'b1);
      checkOutput("both0_flushM", d_FlushM, 1'b0);
      applyStimulus();
      checkOutput("both1_stallM", d_StallM, 1'b1);
      applyStimulus();
      checkOutput("both2_stallM", d_StallM, 1'b1);
      applyStimulus();
      MemReqM = 1'b0;
      #1;
      checkOutput("both3_stallM", d_StallM, 1'b0);
      checkOutput("both3_stallE", d_StallE, 1'b1);
      checkOutput("both3_flushM", d_FlushM, 1'b1);
      checkOutput("both3_flushW", d_FlushW, 1'b0);
      applyStimulus();
      checkOutput("both4_stallE", d_StallE, 1'b1);
      applyStimulus();
      checkOutput("both5_rel_stallE", d_StallE, 1'b0);
      MulStartE = 1'b0;
      applyStimulus();

      // Branch during a memory wait takes effect only in the release cycle.
      MemReqM = 1'b1;
      applyStimulus();
      BranchTakenE = 1'b1;
      #1;
      checkOutput("br1_flushD", d_FlushD, 1'b0);
      checkOutput("br1_flushE", d_FlushE, 1'b0);
      applyStimulus();
      checkOutput("br2_flushD", d_FlushD, 1'b0);
      applyStimulus();
      checkOutput("br3_rel_flushD", d_FlushD, 1'b1);
      checkOutput("br3_rel_flushE", d_FlushE, 1'b1);
      clearInputs();
      applyStimulus();

      // PC write pending in E while idle.
      PCSrcE = 1'b1;
      #1;
      checkOutput("pcE_stallF", d_StallF, 1'b1);
      checkOutput("pcE_flushD", d_FlushD, 1'b1);
      checkOutput("pcE_stallD", d_StallD, 1'b0);
      clearInputs();
      applyStimulus();

      // Reset during a memory wait aborts it at once.
      MemReqM = 1'b1;
      applyStimulus();
      checkOutput("rstw_pre_stallM", d_StallM, 1'b1);
      reset_n = 1'b0;
      #1;
      checkOutput("rstw_stallM", d_StallM, 1'b0);
      checkOutput("rstw_stallF", d_StallF, 1'b0);
      checkOutput("rstw_flushW", d_FlushW, 1'b0);
      MemReqM = 1'b0;
      applyStimulus();
      reset_n = 1'b1;
      applyStimulus();
      checkOutput("rstw_idle_stallM", d_StallM, 1'b0);

      // Fresh access after reset gives the full three-cycle stall.
      stall_cycles = 0;
      MemReqM = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (d_StallM) stall_cycles++;
         applyStimulus();
         MemReqM = 1'b0;
      end
      checks++;
      assert (stall_cycles == 3) else begin
         errors++;
         $error("[TB] FAIL post_reset_stall_count observed=%0d expected=3", stall_cycles);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
